// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative 32-bit divider: state encoding,
// operand width, step count and a magnitude helper.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int CNT_W     = $clog2(DIV_ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Magnitude of a two's-complement operand; the most negative value maps
  // onto itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                   input logic               is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle of the divider: input handshake with operands,
// flush, and output handshake with quotient and remainder.
interface div_iter_if;
  import div_iter_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 div_signed;
  logic [DIV_WIDTH-1:0] x;
  logic [DIV_WIDTH-1:0] y;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [DIV_WIDTH-1:0] s;
  logic [DIV_WIDTH-1:0] r;

  modport master (
    output in_valid, div_signed, x, y, flush, out_ready,
    input  in_ready, out_valid, s, r
  );

  modport slave (
    input  in_valid, div_signed, x, y, flush, out_ready,
    output in_ready, out_valid, s, r
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step
  import div_iter_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic [DIV_WIDTH-1:0] quo_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic [DIV_WIDTH-1:0] quo_o,
  output logic                 q_bit_o
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] trial;

  // The partial remainder stays below the divisor, so 33 bits hold both the
  // shifted value and the signed trial difference without overflow.
  assign shifted = {rem_i, quo_i[DIV_WIDTH-1]};
  assign trial   = shifted - {1'b0, div_i};
  assign q_bit_o = ~trial[DIV_WIDTH];
  assign rem_o   = q_bit_o ? trial[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  assign quo_o   = {quo_i[DIV_WIDTH-2:0], q_bit_o};

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned divider: magnitudes on entry, 32 restoring
// steps, sign fix-up into the result registers, valid/ready on both sides.
module div_iter
  import div_iter_pkg::*;
(
  input  logic     div_clk,
  input  logic     reset,
  div_iter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [DIV_WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic                 neg_s_q, neg_r_q;
  logic [DIV_WIDTH-1:0] s_q, r_q;

  logic [DIV_WIDTH-1:0] rem_nx, quo_nx;
  logic                 q_bit;
  logic                 accept;

  div_step u_step (
    .rem_i   (rem_q),
    .quo_i   (quo_q),
    .div_i   (dvs_q),
    .rem_o   (rem_nx),
    .quo_o   (quo_nx),
    .q_bit_o (q_bit)
  );

  assign accept        = (state_q == IDLE) && bus.in_valid && !bus.flush;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (bus.flush) state_d = IDLE;
               else if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (bus.flush || bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_s_q <= 1'b0;
      neg_r_q <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        rem_q   <= '0;
        quo_q   <= abs_val(bus.x, bus.div_signed);
        dvs_q   <= abs_val(bus.y, bus.div_signed);
        // A zero divisor keeps the all-ones quotient unnegated in both modes.
        neg_s_q <= bus.div_signed && (bus.x[DIV_WIDTH-1] ^ bus.y[DIV_WIDTH-1])
                   && (bus.y != '0);
        neg_r_q <= bus.div_signed && bus.x[DIV_WIDTH-1];
      end else if (state_q == CALC && !bus.flush) begin
        if (cnt_q != CNT_LAST) begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + CNT_W'(1);
        end else begin
          s_q <= neg_s_q ? (~quo_q + 1'b1) : quo_q;
          r_q <= neg_r_q ? (~rem_q + 1'b1) : rem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  div_iter_if bus ();

  div_iter dut (
    .div_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] rm);
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      rm = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q  = 32'h8000_0000;
      rm = 32'd0;
    end else if (sgn) begin
      q  = 32'($signed(a) / $signed(b));
      rm = 32'($signed(a) % $signed(b));
    end else begin
      q  = a / b;
      rm = a % b;
    end
  endfunction

  // Accept one request, scramble inputs during the calculation, check latency,
  // result, stability while stalled, and the return to IDLE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int hold);
    logic [31:0] eq, er;
    int lat;
    ref_div(a, b, sgn, eq, er);
    check({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.x = a; bus.y = b; bus.div_signed = sgn; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0; bus.x = $urandom; bus.y = $urandom; bus.div_signed = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " s"}, bus.s, eq);
    check({tag, " r"}, bus.r, er);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " stall valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " stall s"}, bus.s, eq);
      check({tag, " stall r"}, bus.r, er);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " valid after take"}, 32'(bus.out_valid), 32'd0);
    check({tag, " ready after take"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int seen;
    bus.in_valid = 1'b0; bus.div_signed = 1'b0; bus.x = '0; bus.y = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    #12;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset s", bus.s, 32'd0);
    check("reset r", bus.r, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values
    run_op("u100/7", 32'd100, 32'd7, 1'b0, 0);
    run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("u max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op("u div0", 32'h1234_5678, 32'd0, 1'b0, 0);
    run_op("s div0 neg", 32'h8765_4321, 32'd0, 1'b1, 0);
    run_op("stall5", 32'd1000, 32'd33, 1'b0, 5);

    // Flush at step 10 of CALC
    bus.in_valid = 1'b1; bus.x = 32'd55; bus.y = 32'd5; bus.div_signed = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush calc in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("flush calc no result", 32'(seen), 32'd0);
    run_op("after flush 100/7", 32'd100, 32'd7, 1'b0, 0);

    // Flush with a request pending in IDLE blocks acceptance
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.x = 32'd9; bus.y = 32'd3;
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush idle no accept", 32'(bus.in_ready), 32'd1);

    // Flush while holding a completed result
    bus.in_valid = 1'b1; bus.x = 32'd9; bus.y = 32'd3; bus.div_signed = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    check("flush done pre valid", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush done valid", 32'(bus.out_valid), 32'd0);
    check("flush done ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset in the middle of CALC
    bus.in_valid = 1'b1; bus.x = 32'd77; bus.y = 32'd4;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    #1;
    check("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    check("mid reset s", bus.s, 32'd0);
    rst = 1'b0;
    run_op("after reset", 32'hFFFF_FF00, 32'd16, 1'b1, 0);

    // Random operands, small divisors mixed in to exercise large quotients
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(1, 28);
      run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom), i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 32 bits.
REQ-002 div_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  a new division request is present.
REQ-005 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 div_signed  input  1  1 = two's-complement (div.w/mod.w); 0 = unsigned (div.wu/mod.wu).
REQ-007 x  input  32  dividend, sampled on acceptance.
REQ-008 y  input  32  divisor, sampled on acceptance.
REQ-009 flush  input  1  synchronous cancel of any in-flight or pending-result operation.
REQ-010 out_valid  output  1  s and r hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 s  output  32  quotient.
REQ-013 r  output  32  remainder.

Function
REQ-014 The block SHALL use three states: IDLE, CALC and DONE.
REQ-015 Acceptance SHALL occur on an edge where in_valid & in_ready & ~flush; IDLE->CALC, operands and div_signed are latched, and the iteration counter is cleared.
REQ-016 CALC SHALL perform one radix-2 restoring step per cycle on operand magnitudes, 32 steps, then go to DONE.
REQ-017 out_valid SHALL rise exactly 33 cycles after the accepting edge and stay high, with s and r stable, until out_valid & out_ready.
REQ-018 The output handshake SHALL take DONE->IDLE; in_ready SHALL be high the following cycle, with no same-cycle accept in DONE.
REQ-019 Signed mode: s SHALL be negated when sign(x)!=sign(y); r SHALL take the sign of x; |r| < |y|.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give s=0x80000000, r=0 (32-bit wrap, no trap).
REQ-021 y=0 in either mode SHALL give s=0xFFFFFFFF and r=x, with normal 33-cycle latency.
REQ-022 flush in CALC or DONE SHALL force IDLE on the next edge, deassert out_valid, and produce no result.
REQ-023 flush together with in_valid in IDLE SHALL block acceptance.
REQ-024 Input changes outside the accepting edge SHALL NOT affect an in-flight operation.

Reset
REQ-025 reset SHALL force IDLE asynchronously; out_valid=0, s=0, r=0, counter=0, in_ready=1, including mid-CALC and in DONE.
REQ-026 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE/CALC/DONE), DIV_WIDTH=32 and DIV_ITER=32.
REQ-028 One sub-module, div_step, SHALL implement a single restoring step: 33-bit trial subtract and quotient bit.
REQ-029 Sign handling (abs on entry, sign fix on exit) and the FSM/counter SHALL live in div_iter.

Verification
REQ-030 Unsigned x=100, y=7 -> s=14, r=2; out_valid exactly 33 cycles after accept.
REQ-031 Signed: x=-7, y=2 -> s=0xFFFFFFFD, r=0xFFFFFFFF; x=7, y=-2 -> s=0xFFFFFFFD, r=1.
REQ-032 Boundaries:
- signed 0x80000000 / 0xFFFFFFFF -> s=0x80000000, r=0
- unsigned 0xFFFFFFFF / 1 -> s=0xFFFFFFFF, r=0
- x=0x12345678, y=0 -> s=0xFFFFFFFF, r=0x12345678
REQ-033 Flush at step 10 -> out_valid never rises; in_ready=1 next cycle; following 100/7 is correct.
REQ-034 out_ready held low 5 cycles after out_valid -> s, r and out_valid stable; result taken on the 6th cycle; in_ready=1 the cycle after.
REQ-035 reset pulsed mid-CALC -> out_valid=0, in_ready=1 immediately; next operation correct.
